// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared pipeline types: latency encoding and ID stall mux select
package rv32i_types;

    localparam int MAX_LAT_DEF = 4;
    localparam int CNT_W_DEF   = $clog2(MAX_LAT_DEF + 1);

    typedef logic [CNT_W_DEF-1:0] lat_t;

    // All-ones marks a variable-latency destination that retires only on explicit writeback.
    localparam lat_t LAT_VAR  = '1;
    localparam lat_t LAT_LOAD = lat_t'(2);
    localparam lat_t LAT_MUL  = lat_t'(3);

    typedef enum logic {
        control_out = 1'b0,
        stall_out   = 1'b1
    } ctrl_mux_t;

endpackage

// File: rtl/scoreboard_entry.sv
// rtl/scoreboard_entry.sv - one register's pending-write countdown (set > var clear > decrement)
module scoreboard_entry #(
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             freeze_i,
    input  logic             set_i,
    input  logic [CNT_W-1:0] set_val_i,
    input  logic             clr_i,
    output logic             busy_o,
    output logic             is_var_o
);

    localparam logic [CNT_W-1:0] CNT_VAR = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // set_i arrives already qualified by ~freeze; the var clear deliberately is not.
    always_comb begin
        cnt_d = cnt_q;
        if (!freeze_i && cnt_q != '0 && cnt_q != CNT_VAR) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (clr_i && cnt_q == CNT_VAR) begin
            cnt_d = '0;
        end
        if (set_i) begin
            cnt_d = set_val_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o   = (cnt_q != '0);
    assign is_var_o = (cnt_q == CNT_VAR);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage latency scoreboard driving stall controls; HAZARD_PERF_EN adds a stall counter
module hazard_scoreboard
    import rv32i_types::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int MAX_LAT  = MAX_LAT_DEF,
    parameter int CNT_W    = $clog2(MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_we,
    input  logic [CNT_W-1:0]  issue_lat,
    input  logic              wb_var_valid,
    input  logic [ADDR_W-1:0] wb_var_rd,
    output ctrl_mux_t         ctrl_mux,
    output logic              id_reg_we,
    output logic              pc_we,
    output logic              var_busy,
    output logic [31:0]       perf_stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_VAR = '1;

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] is_var;
    logic                src_hz;
    logic                waw_hz;
    logic                stall;
    logic                issue_fire;
    logic [CNT_W-1:0]    set_val;

    assign busy[0]   = 1'b0;
    assign is_var[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        scoreboard_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clk_i     (clk),
            .rst_i     (rst),
            .freeze_i  (freeze),
            .set_i     (issue_fire && rd_addr == ADDR_W'(r)),
            .set_val_i (set_val),
            .clr_i     (wb_var_valid && wb_var_rd == ADDR_W'(r)),
            .busy_o    (busy[r]),
            .is_var_o  (is_var[r])
        );
    end

    assign src_hz = (rs1_used && rs1_addr != '0 && busy[rs1_addr]) ||
                    (rs2_used && rs2_addr != '0 && busy[rs2_addr]);
    // Only a variable-latency writer can be overtaken; fixed latencies retire in order.
    assign waw_hz = rd_we && rd_addr != '0 && is_var[rd_addr];
    assign stall  = issue_valid && !flush && (src_hz || waw_hz);

    // Latency 1 is fully covered by forwarding, so it never occupies the scoreboard.
    assign issue_fire = issue_valid && !flush && !stall && !freeze && rd_we &&
                        rd_addr != '0 && issue_lat != CNT_W'(1);
    assign set_val    = (issue_lat == '0) ? CNT_VAR : issue_lat - 1'b1;

    assign ctrl_mux  = stall ? stall_out : control_out;
    assign id_reg_we = !stall;
    assign pc_we     = !stall;
    assign var_busy  = |is_var;

    always_ff @(posedge clk) begin
        if (!rst && issue_fire) begin
            assert (issue_lat <= CNT_W'(MAX_LAT));
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (stall && !freeze && perf_q != '1) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_used;
    logic        rs2_used;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [2:0]  issue_lat;
    logic        wb_var_valid;
    logic [4:0]  wb_var_rd;
    ctrl_mux_t   ctrl_mux;
    logic        id_reg_we;
    logic        pc_we;
    logic        var_busy;
    logic [31:0] perf_stall_cnt;

    int errors = 0;
    int checks = 0;
    int perf_exp = 0;

    hazard_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_used       (rs1_used),
        .rs2_used       (rs2_used),
        .rd_addr        (rd_addr),
        .rd_we          (rd_we),
        .issue_lat      (issue_lat),
        .wb_var_valid   (wb_var_valid),
        .wb_var_rd      (wb_var_rd),
        .ctrl_mux       (ctrl_mux),
        .id_reg_we      (id_reg_we),
        .pc_we          (pc_we),
        .var_busy       (var_busy),
        .perf_stall_cnt (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        rs1_used     = 1'b0;
        rs2_used     = 1'b0;
        rd_we        = 1'b0;
        flush        = 1'b0;
        freeze       = 1'b0;
        wb_var_valid = 1'b0;
    endtask

    task automatic drive(input int r1, input int u1, input int r2, input int u2,
                         input int rd, input int we, input int lat);
        issue_valid = 1'b1;
        rs1_addr    = 5'(r1);
        rs1_used    = 1'(u1);
        rs2_addr    = 5'(r2);
        rs2_used    = 1'(u2);
        rd_addr     = 5'(rd);
        rd_we       = 1'(we);
        issue_lat   = 3'(lat);
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        ctrl_mux_t exp_mux;
        #1;
        exp_mux = exp ? stall_out : control_out;
        checks++;
        assert (ctrl_mux === exp_mux && pc_we === !exp && id_reg_we === !exp) else begin
            errors++;
            $error("FAIL %s: ctrl_mux=%0d pc_we=%b id_reg_we=%b, expected ctrl_mux=%0d pc_we=%b id_reg_we=%b",
                   tag, ctrl_mux, pc_we, id_reg_we, exp_mux, !exp, !exp);
        end
        if (exp && !freeze) perf_exp++;
    endtask

    task automatic chk_busy(input string tag, input logic exp);
        #1;
        checks++;
        assert (var_busy === exp) else begin
            errors++;
            $error("FAIL %s: var_busy=%b expected %b", tag, var_busy, exp);
        end
    endtask

    task automatic chk_perf(input string tag);
        logic [31:0] exp;
`ifdef HAZARD_PERF_EN
        exp = 32'(perf_exp);
`else
        exp = 32'd0;
`endif
        #1;
        checks++;
        assert (perf_stall_cnt === exp) else begin
            errors++;
            $error("FAIL %s: perf_stall_cnt=%0d expected %0d", tag, perf_stall_cnt, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        drive(0, 0, 0, 0, 0, 0, 0);
        issue_valid = 1'b0;
        wb_var_rd   = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        chk_stall("reset_idle", 1'b0);
        chk_busy("reset_var_busy", 1'b0);
        chk_perf("reset_perf");

        // load x5 lat 2, dependent add: exactly one stall
        drive(0, 0, 0, 0, 5, 1, 2);   chk_stall("ld_issue", 1'b0); tick();
        drive(5, 1, 0, 0, 6, 1, 1);   chk_stall("lu_stall", 1'b1); tick();
        chk_stall("lu_go", 1'b0);     tick();

        // mul x7 lat 3: two stalls
        drive(0, 0, 0, 0, 7, 1, 3);   chk_stall("mul_issue", 1'b0); tick();
        drive(0, 0, 7, 1, 8, 1, 1);   chk_stall("mul_s1", 1'b1); tick();
        chk_stall("mul_s2", 1'b1);    tick();
        chk_stall("mul_go", 1'b0);    tick();

        // same, with three frozen cycles in between: five stalls
        drive(0, 0, 0, 0, 7, 1, 3);   chk_stall("mulf_issue", 1'b0); tick();
        drive(0, 0, 7, 1, 8, 1, 1);   chk_stall("mulf_s1", 1'b1); tick();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_stall("mulf_frozen", 1'b1);
            tick();
        end
        freeze = 1'b0;
        chk_stall("mulf_s5", 1'b1);   tick();
        chk_stall("mulf_go", 1'b0);   tick();

        // div x9 variable latency
        drive(0, 0, 0, 0, 9, 1, 0);   chk_stall("div_issue", 1'b0); chk_busy("div_busy_before", 1'b0); tick();
        drive(9, 1, 0, 0, 10, 1, 1);  chk_stall("div_s1", 1'b1); chk_busy("div_busy", 1'b1); tick();
        chk_stall("div_s2", 1'b1);    tick();
        wb_var_valid = 1'b1; wb_var_rd = 5'd8;
        chk_stall("div_wrong_wb", 1'b1); tick();
        wb_var_valid = 1'b0;
        drive(3, 1, 0, 0, 3, 1, 1);   chk_stall("indep_x3", 1'b0); chk_busy("div_busy_indep", 1'b1); tick();
        drive(9, 1, 0, 0, 10, 1, 1);
        wb_var_valid = 1'b1; wb_var_rd = 5'd9;
        chk_stall("div_wb_cycle", 1'b1); chk_busy("busy_wb_cycle", 1'b1); tick();
        wb_var_valid = 1'b0;
        chk_stall("div_go", 1'b0);    chk_busy("busy_cleared", 1'b0); tick();
        idle();

        // WAW against a pending div, x0 never stalls
        drive(0, 0, 0, 0, 9, 1, 0);   chk_stall("waw_div_issue", 1'b0); tick();
        drive(0, 0, 0, 0, 9, 1, 3);   chk_stall("waw_stall", 1'b1); tick();
        chk_stall("waw_stall2", 1'b1);
        drive(0, 1, 0, 1, 0, 1, 3);   chk_stall("x0_nostall", 1'b0); tick();
        drive(0, 0, 0, 0, 9, 1, 3);
        wb_var_valid = 1'b1; wb_var_rd = 5'd9;
        chk_stall("waw_wb_cycle", 1'b1); tick();
        wb_var_valid = 1'b0;
        chk_stall("waw_go", 1'b0);    tick();
        drive(0, 0, 0, 0, 10, 1, 3);  chk_stall("fix_issue", 1'b0); tick();
        drive(0, 0, 0, 0, 10, 1, 1);  chk_stall("waw_fixed_nostall", 1'b0); tick();
        idle(); tick(); tick();

        // flush squashes stall and issue
        drive(0, 0, 0, 0, 5, 1, 2);   chk_stall("fl_ld_issue", 1'b0); tick();
        drive(5, 1, 0, 0, 11, 1, 3);  flush = 1'b1; chk_stall("flush_nostall", 1'b0); tick();
        flush = 1'b0;
        drive(11, 1, 5, 1, 12, 1, 1); chk_stall("flush_noset", 1'b0); tick();

        // reissue to x4 while its counter decrements: set wins, two stalls follow
        drive(0, 0, 0, 0, 4, 1, 2);   chk_stall("x4_first", 1'b0); tick();
        drive(0, 0, 0, 0, 4, 1, 3);   chk_stall("x4_reissue", 1'b0); tick();
        drive(4, 1, 0, 0, 6, 1, 1);   chk_stall("x4_s1", 1'b1); tick();
        chk_stall("x4_s2", 1'b1);     tick();
        chk_stall("x4_go", 1'b0);     tick();

        // freeze blocks issue; writeback still clears during freeze
        drive(0, 0, 0, 0, 12, 1, 3);  freeze = 1'b1; chk_stall("frz_issue", 1'b0); tick();
        freeze = 1'b0;
        drive(12, 1, 0, 0, 6, 1, 1);  chk_stall("frz_noset", 1'b0); tick();
        drive(0, 0, 0, 0, 13, 1, 0);  tick();
        idle();                       chk_busy("x13_busy", 1'b1);
        freeze = 1'b1; wb_var_valid = 1'b1; wb_var_rd = 5'd13;
        tick();
        idle();                       chk_busy("frz_wb_clear", 1'b0);

        // reset mid-operation
        drive(0, 0, 0, 0, 14, 1, 0);  tick();
        drive(0, 0, 0, 0, 15, 1, 3);  tick();
        drive(15, 1, 14, 1, 16, 1, 3); chk_stall("pre_rst_stall", 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        perf_exp = 0;
        chk_perf("rst_perf");
        chk_busy("rst_busy", 1'b0);
        chk_stall("rst_nostall", 1'b0); tick();
        idle(); tick(); tick();

        // ten load-use pairs
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 5, 1, 2); chk_stall("perf_ld", 1'b0); tick();
            drive(5, 1, 0, 0, 6, 1, 1); chk_stall("perf_stall", 1'b1); tick();
            chk_stall("perf_go", 1'b0); tick();
        end
        idle();
        chk_perf("perf_ten_pairs");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
